// File: rtl/mult_div_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FIX    = 2'b10,
    FINISH = 2'b11
  } state_e;

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the datapath: shift-add multiply or restoring shift-subtract divide.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             geq;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    // partial remainder stays below 2*divisor, so the W-bit difference is exact when geq
    geq     = shifted[WIDTH] || (shifted[WIDTH-1:0] >= operand);
    diff    = shifted[WIDTH-1:0] - operand;
    if (is_div) begin
      hi_out = geq ? diff : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], geq};
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit: one result bit per cycle, sign fix-up at the end.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  localparam int CYCLES = WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             STALL_REQ,
  output logic             DONE,
  output logic             DIV_BY_ZERO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  state_e           state;
  op_e              op_q;
  logic [CW-1:0]    count;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] hi_acc, lo_acc, opnd;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic             signed_in, is_div;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

  always_comb begin
    signed_in = (OP == OP_MULT) || (OP == OP_DIV);
    a_abs     = (signed_in && A[WIDTH-1]) ? -A : A;
    b_abs     = (signed_in && B[WIDTH-1]) ? -B : B;
  end

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .hi_in   (hi_acc),
    .lo_in   (lo_acc),
    .operand (opnd),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Divide by zero: the restoring loop leaves |A| as remainder, so the normal
  // remainder sign rule already yields HI=A; only the quotient is overridden.
  always_comb begin
    prod   = {hi_acc, lo_acc};
    fix_hi = hi_acc;
    fix_lo = lo_acc;
    if (!is_div) begin
      if (a_neg ^ b_neg) prod = -prod;
      {fix_hi, fix_lo} = prod;
    end else begin
      fix_hi = a_neg ? -hi_acc : hi_acc;
      if (opnd == '0)          fix_lo = '1;
      else if (a_neg ^ b_neg)  fix_lo = -lo_acc;
    end
  end

  assign STALL_REQ = !RESET &&
                     (((state == IDLE) && START) || (state == CALC) || (state == FIX));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= IDLE;
      count       <= '0;
      HI          <= '0;
      LO          <= '0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            op_q   <= op_e'(OP);
            a_neg  <= signed_in && A[WIDTH-1];
            b_neg  <= signed_in && B[WIDTH-1];
            hi_acc <= '0;
            lo_acc <= OP[1] ? a_abs : b_abs;
            opnd   <= OP[1] ? b_abs : a_abs;
            count  <= CW'(CYCLES - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          hi_acc <= step_hi;
          lo_acc <= step_lo;
          if (count == '0) state <= FIX;
          else             count <= count - 1'b1;
        end
        FIX: begin
          HI          <= fix_hi;
          LO          <= fix_lo;
          DONE        <= 1'b1;
          DIV_BY_ZERO <= is_div && (opnd == '0);
          state       <= FINISH;
        end
        FINISH: begin
          DONE        <= 1'b0;
          DIV_BY_ZERO <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results queued at START, checked at DONE.
module tb_mult_div_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] A, B;
  logic        STALL_REQ, DONE, DIV_BY_ZERO;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .START       (START),
    .OP          (OP),
    .A           (A),
    .B           (B),
    .STALL_REQ   (STALL_REQ),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference: {div_by_zero, hi, lo} from 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit timing, input int poke, input string name);
    logic [64:0] exp;
    int done_cycle, stall_cycles, last_stall, stray;
    exp_q.push_back(model(op, a, b));
    @(negedge CLOCK);
    START = 1'b1; OP = op; A = a; B = b;
    #1;
    stall_cycles = STALL_REQ ? 1 : 0;
    last_stall = 0; done_cycle = -1; stray = 0;
    for (int c = 1; c <= 100 && done_cycle < 0; c++) begin
      @(negedge CLOCK);
      START = (c == poke);
      OP = 2'($urandom); A = $urandom; B = $urandom;
      #1;
      if (STALL_REQ) begin stall_cycles++; last_stall = c; end
      if (DONE) done_cycle = c;
      else if (DIV_BY_ZERO) stray++;
    end
    exp = exp_q.pop_front();
    total++;
    if (done_cycle < 0) begin
      bad++;
      $display("FAIL %s timeout: no DONE within 100 cycles", name);
      return;
    end
    total++;
    if ({DIV_BY_ZERO, HI, LO} !== exp) begin
      bad++;
      $display("FAIL %s result: got dbz=%0b hi=%08h lo=%08h want dbz=%0b hi=%08h lo=%08h",
               name, DIV_BY_ZERO, HI, LO, exp[64], exp[63:32], exp[31:0]);
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL %s stray_dbz: got %0d cycles want 0", name, stray);
    end
    if (timing) begin
      total++;
      if (done_cycle !== 34) begin
        bad++;
        $display("FAIL %s done_cycle: got %0d want 34", name, done_cycle);
      end
      total++;
      if (stall_cycles !== 34 || last_stall !== 33) begin
        bad++;
        $display("FAIL %s stall: got count=%0d last=%0d want count=34 last=33",
                 name, stall_cycles, last_stall);
      end
    end
    @(negedge CLOCK);
    START = 1'b0;
    #1;
    total++;
    if ({DONE, DIV_BY_ZERO} !== 2'b00 || {HI, LO} !== exp[63:0]) begin
      bad++;
      $display("FAIL %s after_done: got done=%0b dbz=%0b hi=%08h lo=%08h want 0 0 %08h %08h",
               name, DONE, DIV_BY_ZERO, HI, LO, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset();
    START = 1'b1; OP = 2'b01; A = 32'd5; B = 32'd9; RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    #1;
    total++;
    if (STALL_REQ !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %0b want 0", STALL_REQ);
    end
    total++;
    if ({DONE, DIV_BY_ZERO, HI, LO} !== 66'd0) begin
      bad++;
      $display("FAIL reset_state: got done=%0b dbz=%0b hi=%08h lo=%08h want all 0",
               DONE, DIV_BY_ZERO, HI, LO);
    end
    RESET = 1'b0; START = 1'b0;
    @(negedge CLOCK);
    #1;
    total++;
    if (STALL_REQ !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got stall=%0b done=%0b want 0 0", STALL_REQ, DONE);
    end
  endtask

  task automatic test_multu();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "multu_max");
  endtask

  task automatic test_mult();
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, "mult_neg3x7");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, "mult_minxmin");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_neg7by2");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_min_by_m1");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, "div_7by_neg2");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, "divu_big");
  endtask

  task automatic test_div_zero();
    run_op(2'b11, 32'd100, 32'd0, 1'b1, 0, "divu_zero");
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 0, "div_neg_zero");
  endtask

  task automatic test_back_to_back();
    run_op(2'b01, 32'd12345, 32'd678, 1'b1, 5, "restart_ignored");
    run_op(2'b10, 32'd1000, 32'd7, 1'b0, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge CLOCK);
    START = 1'b1; OP = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLOCK);
      START = 1'b0;
    end
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    total++;
    if (STALL_REQ !== 1'b0 || {HI, LO} !== 64'd0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got stall=%0b done=%0b hi=%08h lo=%08h want 0 0 0 0",
               STALL_REQ, DONE, HI, LO);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK);
      #1;
      if (DONE || STALL_REQ) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones);
    end
    run_op(2'b01, 32'd6, 32'd7, 1'b1, 0, "multu_after_reset");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i);
      a  = $urandom;
      b  = (i >= 6) ? 32'($urandom_range(1, 3)) : $urandom;
      if (i == 5) a = $urandom_range(0, 9);
      run_op(op, a, b, 1'b0, 0, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; START = 1'b0; OP = 2'b00; A = '0; B = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
